// File: rtl/noc_endpoint.sv
// Tile-side network interface: packs core messages into flits toward the router
// and filters/delivers router flits to the core. Optional stats via NOC_EP_STATS_EN.

module noc_ep_fifo #(
    parameter int unsigned W     = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         empty,
    output logic         full
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    // Status depends only on the registered count, never on the request inputs.
    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: stale entries are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end
endmodule

module noc_endpoint #(
    parameter logic [3:0]  XCOORD = 4'b0001,
    parameter logic [3:0]  YCOORD = 4'b0001,
    parameter int unsigned DATA_W = 24,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_valid_i,
    output logic              tx_ready_o,
    input  logic [1:0]        tx_dst_x_i,
    input  logic [1:0]        tx_dst_y_i,
    input  logic [DATA_W-1:0] tx_data_i,
    output logic              rx_valid_o,
    input  logic              rx_ready_i,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              net_tx_valid_o,
    input  logic              net_tx_ready_i,
    output logic [DATA_W+7:0] net_tx_flit_o,
    input  logic              net_rx_valid_i,
    output logic              net_rx_ready_o,
    input  logic [DATA_W+7:0] net_rx_flit_i,
    output logic              err_misroute_o,
    output logic [15:0]       tx_count_o,
    output logic [15:0]       rx_count_o
);
    localparam int unsigned FLIT_W = DATA_W + 8;

    logic [FLIT_W-1:0] tx_flit;
    logic              tx_full;
    logic              tx_empty;
    logic              rx_full;
    logic              rx_empty;
    logic              rx_accept;
    logic              dst_match;
    logic              rx_push;

    // Destination indices become one-hot fields; own-tile traffic still goes out.
    assign tx_flit = {4'(4'b0001 << tx_dst_x_i), 4'(4'b0001 << tx_dst_y_i), tx_data_i};

    noc_ep_fifo #(.W(FLIT_W), .DEPTH(DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_valid_i),
        .wdata (tx_flit),
        .pop   (net_tx_ready_i),
        .rdata (net_tx_flit_o),
        .empty (tx_empty),
        .full  (tx_full)
    );

    assign tx_ready_o     = !tx_full;
    assign net_tx_valid_o = !tx_empty;

    // Mismatched flits are consumed but never stored.
    assign net_rx_ready_o = !rx_full;
    assign rx_accept      = net_rx_valid_i && !rx_full;
    assign dst_match      = (net_rx_flit_i[FLIT_W-1:DATA_W+4] == XCOORD) &&
                            (net_rx_flit_i[DATA_W+3:DATA_W] == YCOORD);
    assign rx_push        = rx_accept && dst_match;

    noc_ep_fifo #(.W(DATA_W), .DEPTH(DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .wdata (net_rx_flit_i[DATA_W-1:0]),
        .pop   (rx_ready_i),
        .rdata (rx_data_o),
        .empty (rx_empty),
        .full  (rx_full)
    );

    assign rx_valid_o = !rx_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_misroute_o <= 1'b0;
        else     err_misroute_o <= rx_accept && !dst_match;
    end

`ifdef NOC_EP_STATS_EN
    logic        tx_fire;
    logic [15:0] tx_cnt;
    logic [15:0] rx_cnt;

    assign tx_fire = net_tx_valid_o && net_tx_ready_i;

    // Saturating event counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_cnt <= 16'h0000;
            rx_cnt <= 16'h0000;
        end else begin
            if (tx_fire && (tx_cnt != 16'hFFFF)) tx_cnt <= tx_cnt + 16'd1;
            if (rx_push && (rx_cnt != 16'hFFFF)) rx_cnt <= rx_cnt + 16'd1;
        end
    end

    assign tx_count_o = tx_cnt;
    assign rx_count_o = rx_cnt;
`else
    assign tx_count_o = 16'h0000;
    assign rx_count_o = 16'h0000;
`endif
endmodule
